adder_stim_checker: RTL and testbench

Self-checking stimulus and response stage that wraps the 32-bit adder comparison harness.
- Upstream side: drives A, B and Sel into the harness from two LFSRs.
- Downstream side: consumes the harness's registered 40-bit Result, compares it against a delay-matched golden sum, and reports vector and error counts.
- Purpose: lets every RCA/CSA/MUL adder combination be exercised on the board or in gate-level simulation without an external pattern source.

---
 rtl/adder_test_pkg.sv | 26 ++
 rtl/lfsr32.sv | 25 ++
 rtl/adder_stim_checker.sv | 168 ++++++++++++++++
 tb/tb_adder_stim_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_test_pkg.sv
// Shared types and constants for the adder stimulus/checker stage.
package adder_test_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RES_W  = 40;

   localparam logic [DATA_W-1:0] DEF_POLY   = 32'h8020_0003;
   localparam logic [DATA_W-1:0] DEF_SEED_A = 32'h0000_0001;
   localparam logic [DATA_W-1:0] DEF_SEED_B = 32'h0000_0002;

   localparam logic [15:0] ERR_NONE = 16'hFFFF;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // One entry of the golden pipe that travels alongside an issued vector
   typedef struct packed {
      logic             valid;
      logic [15:0]      idx;
      logic [RES_W-1:0] exp;
   } gold_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous reload to its seed.
module lfsr32
   import adder_test_pkg::*;
#(
   parameter logic [DATA_W-1:0] POLY = DEF_POLY,
   parameter logic [DATA_W-1:0] SEED = DEF_SEED_A
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              load,
   input  logic              step,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         q <= SEED;
      end else if (load) begin
         q <= SEED;
      end else if (step) begin
         q <= q[0] ? ((q >> 1) ^ POLY) : (q >> 1);
      end
   end

endmodule

// File: rtl/adder_stim_checker.sv
// Drives LFSR operands into the adder harness and checks its registered result
// against a delay-matched golden sum.
module adder_stim_checker
   import adder_test_pkg::*;
#(
   parameter int unsigned       LATENCY = 2,
   parameter logic [DATA_W-1:0] SEED_A  = DEF_SEED_A,
   parameter logic [DATA_W-1:0] SEED_B  = DEF_SEED_B,
   parameter logic [DATA_W-1:0] POLY    = DEF_POLY
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [15:0]       num_vectors,
   output logic [DATA_W-1:0] A_out,
   output logic [DATA_W-1:0] B_out,
   output logic              Sel_out,
   input  logic [RES_W-1:0]  Result_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       vec_count,
   output logic [15:0]       err_count,
   output logic [15:0]       first_err_idx
);

   // Stage 0 is loaded in parallel with A_out; the tail lines up with Result_in.
   localparam int unsigned PIPE_D = LATENCY + 1;

   state_t state_q, state_d;

   logic [15:0]       num_q;
   logic [15:0]       issue_cnt_q;
   logic [15:0]       drain_cnt_q;
   gold_t             pipe_q [PIPE_D];
   gold_t             tail;
   logic [DATA_W-1:0] lfsr_a, lfsr_b;
   logic              accept, issue, enter_done;
   logic [15:0]       vec_d, err_d, first_d;
   logic              pass_d;

   lfsr32 #(.POLY(POLY), .SEED(SEED_A)) u_lfsr_a (
      .clk  (clk),
      .RST  (RST),
      .load (accept),
      .step (issue),
      .q    (lfsr_a)
   );

   lfsr32 #(.POLY(POLY), .SEED(SEED_B)) u_lfsr_b (
      .clk  (clk),
      .RST  (RST),
      .load (accept),
      .step (issue),
      .q    (lfsr_b)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      enter_done = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (num_vectors == 16'd0) begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (issue_cnt_q == num_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt_q == 16'(LATENCY - 1)) begin
               state_d    = DONE;
               enter_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == RUN) || (state_q == DRAIN);
      accept = start && ((state_q == IDLE) || (state_q == DONE));
      issue  = (state_q == RUN) && (issue_cnt_q != num_q);
   end

   assign tail = pipe_q[PIPE_D-1];

   always_comb begin
      vec_d   = vec_count;
      err_d   = err_count;
      first_d = first_err_idx;
      if (accept) begin
         vec_d   = 16'd0;
         err_d   = 16'd0;
         first_d = ERR_NONE;
      end else if (tail.valid) begin
         vec_d = vec_count + 16'd1;
         if (Result_in != tail.exp) begin
            err_d = sat_inc(err_count);
            if (err_count == 16'd0) first_d = tail.idx;
         end
      end
      pass_d = pass;
      if (enter_done) begin
         pass_d = (err_d == 16'd0);
      end else if (accept) begin
         pass_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         A_out         <= '0;
         B_out         <= '0;
         Sel_out       <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         vec_count     <= 16'd0;
         err_count     <= 16'd0;
         first_err_idx <= ERR_NONE;
         num_q         <= 16'd0;
         issue_cnt_q   <= 16'd0;
         drain_cnt_q   <= 16'd0;
         for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
      end else begin
         done          <= enter_done;
         pass          <= pass_d;
         vec_count     <= vec_d;
         err_count     <= err_d;
         first_err_idx <= first_d;
         if (accept) begin
            num_q       <= num_vectors;
            issue_cnt_q <= 16'd0;
         end else if (issue) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
         end
         if (state_q == RUN) begin
            drain_cnt_q <= 16'd0;
         end else if (state_q == DRAIN) begin
            drain_cnt_q <= drain_cnt_q + 16'd1;
         end
         if (issue) begin
            A_out     <= lfsr_a;
            B_out     <= lfsr_b;
            Sel_out   <= lfsr_b[0];
            pipe_q[0] <= '{valid: 1'b1, idx: issue_cnt_q,
                           exp: {{(RES_W-DATA_W-1){1'b0}}, {1'b0, lfsr_a} + {1'b0, lfsr_b}}};
         end else begin
            pipe_q[0] <= '0;
         end
         for (int i = 1; i < PIPE_D; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

endmodule

// File: tb/tb_adder_stim_checker.sv
// Self-checking bench: echo-model harness plus a scoreboard of expected vectors.
module tb_adder_stim_checker;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sel;
   } vec_t;

   logic        clk = 1'b0;
   logic        RST;
   logic        start;
   logic [15:0] num_vectors;
   logic [31:0] A_out, B_out;
   logic        Sel_out;
   logic [39:0] Result_in;
   logic        busy, done, pass;
   logic [15:0] vec_count, err_count, first_err_idx;

   logic [39:0] h1 = '0, h2 = '0, h3 = '0;
   logic        delay3 = 1'b0;
   logic        corrupt = 1'b0;
   logic [39:0] corrupt_val = '0;

   int checks = 0;
   int errors = 0;
   vec_t sb_q[$];

   adder_stim_checker dut (
      .clk           (clk),
      .RST           (RST),
      .start         (start),
      .num_vectors   (num_vectors),
      .A_out         (A_out),
      .B_out         (B_out),
      .Sel_out       (Sel_out),
      .Result_in     (Result_in),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .vec_count     (vec_count),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   always #5 clk = ~clk;

   // Harness echo model: input register then output register
   always @(posedge clk) begin
      h1 <= {7'b0, {1'b0, A_out} + {1'b0, B_out}};
      h2 <= h1;
      h3 <= h2;
   end

   assign Result_in = (delay3 ? h3 : h2) ^ {39'b0, (corrupt && (h2 == corrupt_val))};

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [63:0] model_ab(input int k);
      logic [31:0] a, b;
      a = 32'h1;
      b = 32'h2;
      for (int i = 0; i < k; i++) begin
         a = lfsr_next(a);
         b = lfsr_next(b);
      end
      return {a, b};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] n);
      @(negedge clk);
      num_vectors = n;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_test(input int n, input int exp_err, input logic [15:0] exp_first,
                           input bit exp_pass, input bit inject_start);
      logic [63:0] ab;
      vec_t v;
      int cyc;
      for (int i = 0; i < n; i++) begin
         ab    = model_ab(i);
         v.a   = ab[63:32];
         v.b   = ab[31:0];
         v.sel = ab[0];
         sb_q.push_back(v);
      end
      do_start(16'(n));
      cyc = 0;
      while (!done && cyc < n + 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (inject_start) begin
            if (cyc == 2) begin
               start       = 1'b1;
               num_vectors = 16'd9;
            end else if (cyc == 3) begin
               start = 1'b0;
            end
         end
         if (cyc <= n && sb_q.size() > 0) begin
            v = sb_q.pop_front();
            check("a_out", A_out, v.a);
            check("b_out", B_out, v.b);
            check("sel_out", Sel_out, v.sel);
         end
      end
      check("done_seen", done, 1);
      if (done) check("done_latency", cyc, (n == 0) ? 0 : n + 3);
      check("pass", pass, exp_pass);
      check("vec_count", vec_count, n);
      check("err_count", err_count, exp_err);
      check("first_err_idx", first_err_idx, exp_first);
      check("busy_done", busy, 0);
      @(posedge clk);
      #1;
      check("done_pulse_len", done, 0);
      check("pass_hold", pass, exp_pass);
      sb_q.delete();
   endtask

   initial begin
      logic [63:0] ab;
      bit seen;
      RST         = 1'b1;
      start       = 1'b0;
      num_vectors = 16'd0;
      #1;
      check("rst_a", A_out, 0);
      check("rst_b", B_out, 0);
      check("rst_sel", Sel_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_vec", vec_count, 0);
      check("rst_err", err_count, 0);
      check("rst_first", first_err_idx, 16'hFFFF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      RST = 1'b0;

      // Clean echo run
      run_test(4, 0, 16'hFFFF, 1'b1, 1'b0);

      // Corrupt vector 2 only
      corrupt_val = {7'b0, {1'b0, model_ab(2) >> 32} + {1'b0, model_ab(2) & 64'hFFFF_FFFF}};
      corrupt     = 1'b1;
      run_test(4, 1, 16'd2, 1'b0, 1'b0);
      corrupt = 1'b0;

      // Zero-length run leaves the operand outputs alone
      run_test(0, 0, 16'hFFFF, 1'b1, 1'b0);
      ab = model_ab(3);
      check("a_hold", A_out, ab[63:32]);
      check("b_hold", B_out, ab[31:0]);

      // Start while busy is ignored
      run_test(4, 0, 16'hFFFF, 1'b1, 1'b1);

      // Reset mid-run
      do_start(16'd4);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      RST = 1'b1;
      #1;
      check("abort_a", A_out, 0);
      check("abort_b", B_out, 0);
      check("abort_busy", busy, 0);
      check("abort_vec", vec_count, 0);
      check("abort_first", first_err_idx, 16'hFFFF);
      @(negedge clk);
      RST  = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);
      run_test(4, 0, 16'hFFFF, 1'b1, 1'b0);

      // Harness one cycle slower than expected: every vector mismatches
      delay3 = 1'b1;
      run_test(8, 8, 16'd0, 1'b0, 1'b0);
      delay3 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
